// File: rtl/axi_mem_responder.sv
// AXI4 slave that turns single-ID bursts into word accesses on a simple always-granted SRAM port.
// Optional AXI_MEM_RESPONDER_RANGE_CHECK_EN: flag beats beyond the memory instead of aliasing.
module axi_mem_responder #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 6,
    parameter int unsigned AXI_ID_WIDTH   = 3,
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      test_en_i,

    input  logic                      axi_slave_aw_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_aw_addr_i,
    input  logic [2:0]                axi_slave_aw_prot_i,
    input  logic [3:0]                axi_slave_aw_region_i,
    input  logic [7:0]                axi_slave_aw_len_i,
    input  logic [2:0]                axi_slave_aw_size_i,
    input  logic [1:0]                axi_slave_aw_burst_i,
    input  logic                      axi_slave_aw_lock_i,
    input  logic [3:0]                axi_slave_aw_cache_i,
    input  logic [3:0]                axi_slave_aw_qos_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_slave_aw_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_slave_aw_user_i,
    output logic                      axi_slave_aw_ready_o,

    input  logic                      axi_slave_ar_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_ar_addr_i,
    input  logic [2:0]                axi_slave_ar_prot_i,
    input  logic [3:0]                axi_slave_ar_region_i,
    input  logic [7:0]                axi_slave_ar_len_i,
    input  logic [2:0]                axi_slave_ar_size_i,
    input  logic [1:0]                axi_slave_ar_burst_i,
    input  logic                      axi_slave_ar_lock_i,
    input  logic [3:0]                axi_slave_ar_cache_i,
    input  logic [3:0]                axi_slave_ar_qos_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_slave_ar_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_slave_ar_user_i,
    output logic                      axi_slave_ar_ready_o,

    input  logic                      axi_slave_w_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0] axi_slave_w_data_i,
    input  logic [AXI_STRB_WIDTH-1:0] axi_slave_w_strb_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_slave_w_user_i,
    input  logic                      axi_slave_w_last_i,
    output logic                      axi_slave_w_ready_o,

    output logic                      axi_slave_r_valid_o,
    output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
    output logic [1:0]                axi_slave_r_resp_o,
    output logic                      axi_slave_r_last_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o,
    input  logic                      axi_slave_r_ready_i,

    output logic                      axi_slave_b_valid_o,
    output logic [1:0]                axi_slave_b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o,
    input  logic                      axi_slave_b_ready_i,

    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [AXI_DATA_WIDTH-1:0] mem_wdata_o,
    output logic [AXI_STRB_WIDTH-1:0] mem_be_o,
    input  logic [AXI_DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned OFFS = $clog2(AXI_STRB_WIDTH);

    typedef enum logic [2:0] {StIdle, StWrite, StWriteResp, StReadWait, StReadData} state_e;

    state_e                    state_q, state_d;
    logic                      prio_wr_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q, cnt_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic                      err_q, rd_err_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                rresp_q;

    logic                      aw_ready, ar_ready, w_ready, r_valid, b_valid;
    logic                      aw_hs, ar_hs, wr_beat, beat_last, rd_issue, rd_oor, wr_oor;
    logic [AXI_ADDR_WIDTH-1:0] addr_nxt, rd_addr;

    // WRAP keeps the low bits inside the (len+1)<<size window and holds the aligned base.
    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
        input logic [AXI_ADDR_WIDTH-1:0] a,
        input logic [7:0]                len,
        input logic [2:0]                size,
        input logic [1:0]                burst
    );
        logic [AXI_ADDR_WIDTH-1:0] incr, span, mask;
        logic [8:0]                len_p1;
        incr   = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
        len_p1 = {1'b0, len} + 9'd1;
        span   = {{(AXI_ADDR_WIDTH-9){1'b0}}, len_p1} << size;
        mask   = span - {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1};
        unique case (burst)
            2'b00:   next_addr = a;
            2'b10:   next_addr = (a & ~mask) | ((a + incr) & mask);
            default: next_addr = a + incr;
        endcase
    endfunction

    assign beat_last = (cnt_q == len_q);
    assign addr_nxt  = next_addr(addr_q, len_q, size_q, burst_q);
    assign aw_hs     = aw_ready & axi_slave_aw_valid_i;
    assign ar_hs     = ar_ready & axi_slave_ar_valid_i;
    assign wr_beat   = (state_q == StWrite) & axi_slave_w_valid_i;
    assign rd_issue  = ar_hs |
                       ((state_q == StReadData) & axi_slave_r_ready_i & ~beat_last);
    assign rd_addr   = (state_q == StIdle) ? axi_slave_ar_addr_i : addr_nxt;

`ifdef AXI_MEM_RESPONDER_RANGE_CHECK_EN
    assign rd_oor = |(rd_addr >> (OFFS + MEM_ADDR_WIDTH));
    assign wr_oor = |(addr_q >> (OFFS + MEM_ADDR_WIDTH));
`else
    assign rd_oor = 1'b0;
    assign wr_oor = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (aw_hs)      state_d = StWrite;
                else if (ar_hs) state_d = StReadWait;
            end
            StWrite:     if (wr_beat && beat_last) state_d = StWriteResp;
            StWriteResp: if (axi_slave_b_ready_i) state_d = StIdle;
            StReadWait:  state_d = StReadData;
            StReadData:  if (axi_slave_r_ready_i) state_d = beat_last ? StIdle : StReadWait;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        aw_ready = 1'b0;
        ar_ready = 1'b0;
        w_ready  = 1'b0;
        r_valid  = 1'b0;
        b_valid  = 1'b0;
        unique case (state_q)
            StIdle: begin
                aw_ready = axi_slave_aw_valid_i & (~axi_slave_ar_valid_i | prio_wr_q);
                ar_ready = axi_slave_ar_valid_i & (~axi_slave_aw_valid_i | ~prio_wr_q);
            end
            StWrite:     w_ready = 1'b1;
            StWriteResp: b_valid = 1'b1;
            StReadData:  r_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_wr_q <= 1'b1;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            id_q      <= '0;
            err_q     <= 1'b0;
            rd_err_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            if (aw_hs) begin
                prio_wr_q <= 1'b0;
                addr_q    <= axi_slave_aw_addr_i;
                len_q     <= axi_slave_aw_len_i;
                size_q    <= axi_slave_aw_size_i;
                burst_q   <= axi_slave_aw_burst_i;
                id_q      <= axi_slave_aw_id_i;
                cnt_q     <= '0;
                err_q     <= (axi_slave_aw_burst_i == 2'b11);
            end else if (ar_hs) begin
                prio_wr_q <= 1'b1;
                addr_q    <= axi_slave_ar_addr_i;
                len_q     <= axi_slave_ar_len_i;
                size_q    <= axi_slave_ar_size_i;
                burst_q   <= axi_slave_ar_burst_i;
                id_q      <= axi_slave_ar_id_i;
                cnt_q     <= '0;
                err_q     <= 1'b0;
            end else if (wr_beat) begin
                addr_q <= addr_nxt;
                if (!beat_last) cnt_q <= cnt_q + 8'd1;
                if ((axi_slave_w_last_i != beat_last) || wr_oor) err_q <= 1'b1;
            end else if ((state_q == StReadData) && axi_slave_r_ready_i && !beat_last) begin
                addr_q <= addr_nxt;
                cnt_q  <= cnt_q + 8'd1;
            end
            if (rd_issue) rd_err_q <= rd_oor;
            if (state_q == StReadWait) begin
                rdata_q <= rd_err_q ? '0 : mem_rdata_i;
                rresp_q <= (rd_err_q || (burst_q == 2'b11)) ? 2'b10 : 2'b00;
            end
        end
    end

    assign axi_slave_aw_ready_o = aw_ready;
    assign axi_slave_ar_ready_o = ar_ready;
    assign axi_slave_w_ready_o  = w_ready;
    assign axi_slave_r_valid_o  = r_valid;
    assign axi_slave_r_data_o   = rdata_q;
    assign axi_slave_r_resp_o   = rresp_q;
    assign axi_slave_r_last_o   = r_valid & beat_last;
    assign axi_slave_r_id_o     = id_q;
    assign axi_slave_r_user_o   = '0;
    assign axi_slave_b_valid_o  = b_valid;
    assign axi_slave_b_resp_o   = (b_valid && err_q) ? 2'b10 : 2'b00;
    assign axi_slave_b_id_o     = id_q;
    assign axi_slave_b_user_o   = '0;

    assign mem_req_o   = (rd_issue & ~rd_oor) | (wr_beat & ~wr_oor);
    assign mem_we_o    = wr_beat & ~wr_oor;
    assign mem_addr_o  = wr_beat  ? addr_q[OFFS +: MEM_ADDR_WIDTH] :
                         rd_issue ? rd_addr[OFFS +: MEM_ADDR_WIDTH] : '0;
    assign mem_wdata_o = wr_beat ? axi_slave_w_data_i : '0;
    assign mem_be_o    = wr_beat ? axi_slave_w_strb_i : '0;

    logic unused_sigs;
    assign unused_sigs = ^{test_en_i, axi_slave_aw_prot_i, axi_slave_aw_region_i,
                           axi_slave_aw_lock_i, axi_slave_aw_cache_i, axi_slave_aw_qos_i,
                           axi_slave_aw_user_i, axi_slave_ar_prot_i, axi_slave_ar_region_i,
                           axi_slave_ar_lock_i, axi_slave_ar_cache_i, axi_slave_ar_qos_i,
                           axi_slave_ar_user_i, axi_slave_w_user_i, rd_addr};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder with a one-cycle-latency memory model.
module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        test_en;
    logic        aw_valid, aw_lock, aw_ready;
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot, aw_size, aw_id;
    logic [3:0]  aw_region, aw_cache, aw_qos;
    logic [7:0]  aw_len;
    logic [1:0]  aw_burst;
    logic [5:0]  aw_user;
    logic        ar_valid, ar_lock, ar_ready;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot, ar_size, ar_id;
    logic [3:0]  ar_region, ar_cache, ar_qos;
    logic [7:0]  ar_len;
    logic [1:0]  ar_burst;
    logic [5:0]  ar_user;
    logic        w_valid, w_last, w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic [5:0]  w_user;
    logic        r_valid, r_last, r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic [2:0]  r_id;
    logic [5:0]  r_user;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic [2:0]  b_id;
    logic [5:0]  b_user;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
        .axi_slave_aw_valid_i(aw_valid), .axi_slave_aw_addr_i(aw_addr),
        .axi_slave_aw_prot_i(aw_prot), .axi_slave_aw_region_i(aw_region),
        .axi_slave_aw_len_i(aw_len), .axi_slave_aw_size_i(aw_size),
        .axi_slave_aw_burst_i(aw_burst), .axi_slave_aw_lock_i(aw_lock),
        .axi_slave_aw_cache_i(aw_cache), .axi_slave_aw_qos_i(aw_qos),
        .axi_slave_aw_id_i(aw_id), .axi_slave_aw_user_i(aw_user),
        .axi_slave_aw_ready_o(aw_ready),
        .axi_slave_ar_valid_i(ar_valid), .axi_slave_ar_addr_i(ar_addr),
        .axi_slave_ar_prot_i(ar_prot), .axi_slave_ar_region_i(ar_region),
        .axi_slave_ar_len_i(ar_len), .axi_slave_ar_size_i(ar_size),
        .axi_slave_ar_burst_i(ar_burst), .axi_slave_ar_lock_i(ar_lock),
        .axi_slave_ar_cache_i(ar_cache), .axi_slave_ar_qos_i(ar_qos),
        .axi_slave_ar_id_i(ar_id), .axi_slave_ar_user_i(ar_user),
        .axi_slave_ar_ready_o(ar_ready),
        .axi_slave_w_valid_i(w_valid), .axi_slave_w_data_i(w_data),
        .axi_slave_w_strb_i(w_strb), .axi_slave_w_user_i(w_user),
        .axi_slave_w_last_i(w_last), .axi_slave_w_ready_o(w_ready),
        .axi_slave_r_valid_o(r_valid), .axi_slave_r_data_o(r_data),
        .axi_slave_r_resp_o(r_resp), .axi_slave_r_last_o(r_last),
        .axi_slave_r_id_o(r_id), .axi_slave_r_user_o(r_user),
        .axi_slave_r_ready_i(r_ready),
        .axi_slave_b_valid_o(b_valid), .axi_slave_b_resp_o(b_resp),
        .axi_slave_b_id_o(b_id), .axi_slave_b_user_o(b_user),
        .axi_slave_b_ready_i(b_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
    );

    // Memory model: unwritten words read back a pattern derived from their address.
    logic [63:0]     mem [1024];
    bit              wmask [1024];
    int              req_cnt = 0;
    int unsigned     wr_addr_log[$];
    logic [63:0]     wr_data_log[$];
    int unsigned     rd_addr_log[$];

    function automatic logic [63:0] pat(input int unsigned w);
        return 64'hCAFE_0000_0000_0000 | 64'(w);
    endfunction

    function automatic logic [63:0] be_mask(input logic [7:0] be);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{be[b]}};
        return m;
    endfunction

    always @(posedge clk) begin
        if (mem_req) begin
            req_cnt <= req_cnt + 1;
            if (mem_we) begin
                mem[mem_addr]   <= (mem_wdata & be_mask(mem_be)) |
                                   (mem[mem_addr] & ~be_mask(mem_be));
                wmask[mem_addr] <= 1'b1;
                wr_addr_log.push_back(32'(mem_addr));
                wr_data_log.push_back(mem_wdata);
            end else begin
                rd_addr_log.push_back(32'(mem_addr));
                mem_rdata <= wmask[mem_addr] ? mem[mem_addr] : pat(32'(mem_addr));
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] id);
        aw_addr = addr; aw_len = len; aw_size = 3'd3; aw_burst = burst; aw_id = id;
        aw_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (aw_ready) break;
            @(negedge clk);
        end
        check("aw_ready", 64'(aw_ready), 64'd1);
        @(negedge clk);
        aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] id);
        ar_addr = addr; ar_len = len; ar_size = 3'd3; ar_burst = burst; ar_id = id;
        ar_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (ar_ready) break;
            @(negedge clk);
        end
        check("ar_ready", 64'(ar_ready), 64'd1);
        @(negedge clk);
        ar_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic last);
        w_data = data; w_strb = 8'hFF; w_last = last; w_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (w_ready) break;
            @(negedge clk);
        end
        check("w_ready", 64'(w_ready), 64'd1);
        @(negedge clk);
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic recv_r(input string tag, input logic [63:0] data, input logic [1:0] resp,
                          input logic last, input logic [2:0] id, input int stall);
        int snap;
        r_ready = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (r_valid) break;
            @(negedge clk);
        end
        check({tag, ".valid"}, 64'(r_valid), 64'd1);
        check({tag, ".data"}, r_data, data);
        check({tag, ".resp"}, 64'(r_resp), 64'(resp));
        check({tag, ".last"}, 64'(r_last), 64'(last));
        check({tag, ".id"}, 64'(r_id), 64'(id));
        check({tag, ".user"}, 64'(r_user), 64'd0);
        if (stall > 0) begin
            snap = req_cnt;
            repeat (stall) @(negedge clk);
            check({tag, ".stall_valid"}, 64'(r_valid), 64'd1);
            check({tag, ".stall_data"}, r_data, data);
            check({tag, ".stall_last"}, 64'(r_last), 64'(last));
            check({tag, ".stall_noreq"}, 64'(req_cnt), 64'(snap));
        end
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
    endtask

    task automatic recv_b(input string tag, input logic [1:0] resp, input logic [2:0] id);
        b_ready = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (b_valid) break;
            @(negedge clk);
        end
        check({tag, ".valid"}, 64'(b_valid), 64'd1);
        check({tag, ".resp"}, 64'(b_resp), 64'(resp));
        check({tag, ".id"}, 64'(b_id), 64'(id));
        check({tag, ".user"}, 64'(b_user), 64'd0);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int wr0, rd0, req0;
        rst_n = 1'b0; test_en = 1'b0;
        aw_valid = 0; aw_addr = 0; aw_prot = 0; aw_region = 0; aw_len = 0; aw_size = 0;
        aw_burst = 0; aw_lock = 0; aw_cache = 0; aw_qos = 0; aw_id = 0; aw_user = 0;
        ar_valid = 0; ar_addr = 0; ar_prot = 0; ar_region = 0; ar_len = 0; ar_size = 0;
        ar_burst = 0; ar_lock = 0; ar_cache = 0; ar_qos = 0; ar_id = 0; ar_user = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_user = 0; w_last = 0;
        r_ready = 0; b_ready = 0;
        repeat (3) @(negedge clk);
        check("rst.aw_ready", 64'(aw_ready), 64'd0);
        check("rst.w_ready", 64'(w_ready), 64'd0);
        check("rst.r_valid", 64'(r_valid), 64'd0);
        check("rst.b_valid", 64'(b_valid), 64'd0);
        check("rst.mem_req", 64'(mem_req), 64'd0);
        check("rst.r_data", r_data, 64'd0);
        check("rst.b_resp", 64'(b_resp), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // INCR write burst of four beats at 0x10: words 2..5.
        wr0 = wr_addr_log.size();
        send_aw(32'h10, 8'd3, 2'b01, 3'd5);
        for (int i = 0; i < 4; i++) send_w(64'h1111_0000_0000_0000 + 64'(i), i == 3);
        check("wr.count", 64'(wr_addr_log.size() - wr0), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("wr.addr", 64'(wr_addr_log[wr0 + i]), 64'(2 + i));
            check("wr.data", wr_data_log[wr0 + i], 64'h1111_0000_0000_0000 + 64'(i));
        end
        recv_b("b_incr", 2'b00, 3'd5);

        // WRAP read at 0x38: words 7,4,5,6, beat 2 stalled for 5 cycles.
        rd0 = rd_addr_log.size();
        send_ar(32'h38, 8'd3, 2'b10, 3'd2);
        recv_r("r_wrap0", pat(7), 2'b00, 1'b0, 3'd2, 0);
        recv_r("r_wrap1", 64'h1111_0000_0000_0002, 2'b00, 1'b0, 3'd2, 5);
        recv_r("r_wrap2", 64'h1111_0000_0000_0003, 2'b00, 1'b0, 3'd2, 0);
        recv_r("r_wrap3", pat(6), 2'b00, 1'b1, 3'd2, 0);
        check("rd.count", 64'(rd_addr_log.size() - rd0), 64'd4);
        check("rd.addr0", 64'(rd_addr_log[rd0]), 64'd7);
        check("rd.addr1", 64'(rd_addr_log[rd0 + 1]), 64'd4);
        check("rd.addr2", 64'(rd_addr_log[rd0 + 2]), 64'd5);
        check("rd.addr3", 64'(rd_addr_log[rd0 + 3]), 64'd6);

        // len=1 write with w_last on the first beat: two writes, SLVERR.
        wr0 = wr_addr_log.size();
        send_aw(32'h60, 8'd1, 2'b01, 3'd7);
        send_w(64'hAAAA_0000_0000_0000, 1'b1);
        send_w(64'hAAAA_0000_0000_0001, 1'b0);
        recv_b("b_lasterr", 2'b10, 3'd7);
        repeat (3) @(negedge clk);
        check("lasterr.count", 64'(wr_addr_log.size() - wr0), 64'd2);
        check("lasterr.addr0", 64'(wr_addr_log[wr0]), 64'd12);
        check("lasterr.addr1", 64'(wr_addr_log[wr0 + 1]), 64'd13);

        // Reserved burst type reads as INCR with SLVERR.
        send_ar(32'h08, 8'd0, 2'b11, 3'd5);
        recv_r("r_rsvd", pat(1), 2'b10, 1'b1, 3'd5, 0);

        // Address beyond the memory: range error or alias onto word 0.
        req0 = req_cnt;
        send_ar(32'h2000, 8'd0, 2'b01, 3'd1);
`ifdef AXI_MEM_RESPONDER_RANGE_CHECK_EN
        recv_r("r_range", 64'd0, 2'b10, 1'b1, 3'd1, 0);
        check("range.noreq", 64'(req_cnt - req0), 64'd0);
`else
        recv_r("r_alias", pat(0), 2'b00, 1'b1, 3'd1, 0);
        check("alias.req", 64'(req_cnt - req0), 64'd1);
        check("alias.addr", 64'(rd_addr_log[rd_addr_log.size() - 1]), 64'd0);
`endif

        // Reset in the middle of a read burst abandons it.
        send_ar(32'h00, 8'd3, 2'b01, 3'd6);
        recv_r("r_abort0", pat(0), 2'b00, 1'b0, 3'd6, 0);
        rst_n = 1'b0;
        req0  = req_cnt;
        repeat (4) @(negedge clk);
        check("abort.noreq", 64'(req_cnt), 64'(req0));
        check("abort.r_valid", 64'(r_valid), 64'd0);
        check("abort.r_data", r_data, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort.noreq_after", 64'(req_cnt), 64'(req0));
        check("abort.r_valid_after", 64'(r_valid), 64'd0);

        // AW and AR together after reset: AW first, AR served next.
        aw_addr = 32'h40; aw_len = 8'd0; aw_size = 3'd3; aw_burst = 2'b01; aw_id = 3'd3;
        ar_addr = 32'h40; ar_len = 8'd0; ar_size = 3'd3; ar_burst = 2'b01; ar_id = 3'd4;
        aw_valid = 1'b1;
        ar_valid = 1'b1;
        #1;
        check("arb.aw_ready", 64'(aw_ready), 64'd1);
        check("arb.ar_ready", 64'(ar_ready), 64'd0);
        @(negedge clk);
        aw_valid = 1'b0;
        #1;
        check("arb.ar_wait", 64'(ar_ready), 64'd0);
        send_w(64'hBEEF_0000_0000_BEEF, 1'b1);
        check("arb.wr_addr", 64'(wr_addr_log[wr_addr_log.size() - 1]), 64'd8);
        recv_b("b_arb", 2'b00, 3'd3);
        send_ar(32'h40, 8'd0, 2'b01, 3'd4);
        recv_r("r_arb", 64'hBEEF_0000_0000_BEEF, 2'b00, 1'b1, 3'd4, 0);

        req0 = req_cnt;
        repeat (5) @(negedge clk);
        check("idle.noreq", 64'(req_cnt), 64'(req0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
